// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared state encodings and error codes for the UART program loader
package uart_loader_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_IDLE    = 3'd1,
      ST_CNT_MSB = 3'd2,
      ST_DATA    = 3'd3,
      ST_CSUM    = 3'd4,
      ST_DONE    = 3'd5,
      ST_ERROR   = 3'd6
   } loader_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_COUNT   = 2'b01;
   localparam logic [1:0] ERR_CSUM    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam int HEADER_BYTES = 2;

endpackage

// File: rtl/loader_word_asm.sv
// rtl/loader_word_asm.sv - little-endian byte-to-word assembler with byte-lane counter
module loader_word_asm #(
   parameter int WORD_BYTES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    byte_valid,
   input  logic [7:0]              byte_in,
   output logic [8*WORD_BYTES-1:0] word_next,
   output logic                    word_ready
);

   localparam int IW    = 8 * WORD_BYTES;
   localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

   logic [IDX_W-1:0] idx;

   assign word_ready = byte_valid && (idx == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (clear) begin
         idx <= '0;
      end else if (byte_valid) begin
         idx <= word_ready ? '0 : idx + 1'b1;
      end
   end

   generate
      if (WORD_BYTES == 1) begin : g_single
         assign word_next = byte_in;
      end else begin : g_multi
         // Older bytes shift down so the first byte of a word ends up in lane 0.
         logic [IW-9:0] upper;

         assign word_next = {byte_in, upper};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               upper <= '0;
            end else if (clear) begin
               upper <= '0;
            end else if (byte_valid) begin
               upper <= word_next[IW-1:8];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - length-prefixed UART frame loader into instruction memory with CPU reset hold
module uart_prog_loader
   import uart_loader_pkg::*;
#(
   parameter int WORD_BYTES     = 2,
   parameter int ADDR_W         = 16,
   parameter int DEPTH          = 256,
   parameter int ADDR_STEP      = 1,
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int AUTO_START     = 0
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    reload_n,
   input  logic                    start,
   input  logic [7:0]              rx_byte,
   input  logic                    rx_valid,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [8*WORD_BYTES-1:0] mem_wdata,
   output logic [15:0]             loaded_count,
   output logic                    cpu_rst,
   output logic                    cpu_run_en,
   output logic                    done,
   output logic                    err,
   output logic [1:0]              err_code,
   output logic [2:0]              state
);

   loader_state_t state_q, state_d;
   logic [1:0]    err_d;
   logic [15:0]   count_q;
   logic [15:0]   count_full;
   logic [7:0]    csum_q;
   logic [31:0]   tmo_q;
   logic          tmo_active;
   logic          timeout_hit;
   logic          asm_valid;
   logic          word_ready;
   logic [8*WORD_BYTES-1:0] word_next;
   logic [16:0]   words_done;
   logic          last_word;

   assign count_full = {rx_byte, count_q[7:0]};
   assign tmo_active = (state_q == ST_CNT_MSB) || (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && tmo_active && !rx_valid &&
                        (tmo_q == 32'(TIMEOUT_CYCLES - 1));
   assign asm_valid  = rx_valid && reload_n && (state_q == ST_DATA);

   // A write still on mem_we has not reached loaded_count yet, so include it.
   assign words_done = {1'b0, loaded_count} + {16'd0, mem_we} + 17'd1;
   assign last_word  = (words_done == {1'b0, count_q});

   loader_word_asm #(
      .WORD_BYTES(WORD_BYTES)
   ) u_word_asm (
      .clk        (CLK),
      .rst_n      (RESET),
      .clear      (!reload_n),
      .byte_valid (asm_valid),
      .byte_in    (rx_byte),
      .word_next  (word_next),
      .word_ready (word_ready)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_code;
      if (!reload_n) begin
         state_d = ST_IDLE;
         err_d   = ERR_NONE;
      end else if (timeout_hit) begin
         state_d = ST_ERROR;
         err_d   = ERR_TIMEOUT;
      end else begin
         case (state_q)
            ST_IDLE: if (rx_valid) state_d = ST_CNT_MSB;
            ST_CNT_MSB: begin
               if (rx_valid) begin
                  if ({16'd0, count_full} > 32'(DEPTH)) begin
                     state_d = ST_ERROR;
                     err_d   = ERR_COUNT;
                  end else if (count_full == 16'd0) begin
                     state_d = ST_CSUM;
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end
            ST_DATA: if (word_ready && last_word) state_d = ST_CSUM;
            ST_CSUM: begin
               if (rx_valid) begin
                  if (rx_byte == csum_q) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_ERROR;
                     err_d   = ERR_CSUM;
                  end
               end
            end
            ST_DONE: if ((AUTO_START != 0) || start) state_d = ST_RUN;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      state      = state_q;
      cpu_rst    = !((state_q == ST_DONE) || (state_q == ST_RUN));
      cpu_run_en = (state_q == ST_RUN);
      done       = ((state_q == ST_DONE) || (state_q == ST_RUN)) && (err_code == ERR_NONE);
      err        = (state_q == ST_ERROR);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         loaded_count <= '0;
         err_code     <= ERR_NONE;
         count_q      <= '0;
         csum_q       <= '0;
         tmo_q        <= '0;
      end else if (!reload_n) begin
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         loaded_count <= '0;
         err_code     <= ERR_NONE;
         count_q      <= '0;
         csum_q       <= '0;
         tmo_q        <= '0;
      end else begin
         err_code <= err_d;
         mem_we   <= word_ready;
         if (word_ready) begin
            mem_wdata <= word_next;
         end
         if (mem_we) begin
            mem_addr     <= mem_addr + ADDR_W'(ADDR_STEP);
            loaded_count <= loaded_count + 16'd1;
         end
         if (rx_valid && ((state_q == ST_IDLE) || (state_q == ST_CNT_MSB) || (state_q == ST_DATA))) begin
            csum_q <= csum_q ^ rx_byte;
         end
         if (rx_valid && (state_q == ST_IDLE)) begin
            count_q[7:0] <= rx_byte;
         end
         if (rx_valid && (state_q == ST_CNT_MSB)) begin
            count_q[15:8] <= rx_byte;
         end
         if (rx_valid || !tmo_active) begin
            tmo_q <= '0;
         end else begin
            tmo_q <= tmo_q + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - scoreboard bench for uart_prog_loader with directed frames
module tb_uart_prog_loader;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        reload_n = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_valid = 1'b0;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] loaded_count;
   logic        cpu_rst;
   logic        cpu_run_en;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [2:0]  state;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;
   wr_t exp_q[$];

   always #5 CLK = ~CLK;

   uart_prog_loader #(
      .WORD_BYTES     (2),
      .ADDR_W         (16),
      .DEPTH          (256),
      .ADDR_STEP      (1),
      .TIMEOUT_CYCLES (1000),
      .AUTO_START     (0)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .reload_n     (reload_n),
      .start        (start),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .loaded_count (loaded_count),
      .cpu_rst      (cpu_rst),
      .cpu_run_en   (cpu_run_en),
      .done         (done),
      .err          (err),
      .err_code     (err_code),
      .state        (state)
   );

   // Write monitor: every mem_we must match the oldest expected write.
   always @(negedge CLK) begin
      if (RESET && mem_we) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            if (mem_addr !== w.addr || mem_wdata !== w.data) begin
               n_fail++;
               $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                        mem_addr, mem_wdata, w.addr, w.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic reload();
      reload_n = 1'b0;
      @(posedge CLK);
      #1;
      reload_n = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic send_good_frame();
      push_wr(16'h0000, 16'h1234);
      push_wr(16'h0001, 16'hABCD);
      send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'hCD);
      send(8'hAB);
      check("write_pulse_after_last_byte", {31'd0, mem_we}, 32'd1);
      check("write_addr_second_word", {16'd0, mem_addr}, 32'd1);
      send(8'h42);
   endtask

   initial begin
      #1;
      check("reset_state", {29'd0, state}, 32'd0);
      check("reset_mem_we", {31'd0, mem_we}, 32'd0);
      check("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
      check("reset_loaded_count", {16'd0, loaded_count}, 32'd0);
      check("reset_err_code", {30'd0, err_code}, 32'd0);
      check("reset_run_en", {31'd0, cpu_run_en}, 32'd1);
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b1;

      // Valid two-word frame, then start.
      reload();
      check("reload_idle", {29'd0, state}, 32'd1);
      check("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      send_good_frame();
      check("good_done_state", {29'd0, state}, 32'd5);
      check("good_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      check("good_loaded_count", {16'd0, loaded_count}, 32'd2);
      check("good_done_flag", {31'd0, done}, 32'd1);
      check("good_not_running", {31'd0, cpu_run_en}, 32'd0);
      pulse_start();
      check("start_run_state", {29'd0, state}, 32'd0);
      check("start_run_en", {31'd0, cpu_run_en}, 32'd1);

      // Bad checksum: writes still happen, then ERROR.
      reload();
      push_wr(16'h0000, 16'h1234);
      push_wr(16'h0001, 16'hABCD);
      send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'hCD); send(8'hAB);
      send(8'h43);
      check("csum_err_state", {29'd0, state}, 32'd6);
      check("csum_err_code", {30'd0, err_code}, 32'd2);
      check("csum_err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("csum_err_flag", {31'd0, err}, 32'd1);
      check("csum_err_done", {31'd0, done}, 32'd0);
      pulse_start();
      send(8'h55);
      check("error_sticky", {29'd0, state}, 32'd6);

      // Count 257 exceeds DEPTH.
      reload();
      send(8'h01); send(8'h01);
      check("count_err_state", {29'd0, state}, 32'd6);
      check("count_err_code", {30'd0, err_code}, 32'd1);
      check("count_err_loaded", {16'd0, loaded_count}, 32'd0);

      // Mid-frame timeout fires exactly 1000 cycles after the last byte.
      reload();
      send(8'h01); send(8'h00); send(8'h34);
      repeat (999) @(posedge CLK);
      #1;
      check("timeout_not_yet", {29'd0, state}, 32'd3);
      @(posedge CLK);
      #1;
      check("timeout_state", {29'd0, state}, 32'd6);
      check("timeout_code", {30'd0, err_code}, 32'd3);

      // IDLE never times out.
      reload();
      repeat (1100) @(posedge CLK);
      #1;
      check("idle_no_timeout", {29'd0, state}, 32'd1);

      // Empty frame.
      send(8'h00); send(8'h00); send(8'h00);
      check("empty_done", {29'd0, state}, 32'd5);
      check("empty_loaded", {16'd0, loaded_count}, 32'd0);

      // Reload coincident with a DATA byte drops the byte.
      reload();
      send(8'h02); send(8'h00); send(8'h34);
      rx_byte  = 8'h12;
      rx_valid = 1'b1;
      reload_n = 1'b0;
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
      reload_n = 1'b1;
      check("reload_mid_state", {29'd0, state}, 32'd1);
      check("reload_mid_addr", {16'd0, mem_addr}, 32'd0);
      send_good_frame();
      check("after_reload_done", {29'd0, state}, 32'd5);
      check("after_reload_count", {16'd0, loaded_count}, 32'd2);

      // Async reset mid-frame.
      reload();
      send(8'h02); send(8'h00); send(8'h34);
      #2;
      RESET = 1'b0;
      #1;
      check("async_reset_state", {29'd0, state}, 32'd0);
      check("async_reset_we", {31'd0, mem_we}, 32'd0);
      check("async_reset_addr", {16'd0, mem_addr}, 32'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      check("post_reset_run", {29'd0, state}, 32'd0);

      check("pending_writes", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Parametrised UART program loader between the uart_rx byte stream and the instruction memory write port.
- Assembles little-endian multi-byte words from a length-prefixed frame and writes them to sequential addresses.
- Verifies a trailing XOR checksum and an inter-byte timeout, and holds the CPU core in reset until a frame loads cleanly.
- Generalises the 16-bit, fixed-format loader with word width, depth, address step, start mode and error reporting.

Parameters:
- WORD_BYTES, 2: bytes per instruction word (1..4); IW = 8*WORD_BYTES.
- ADDR_W, 16: width of mem_addr.
- DEPTH, 256: maximum accepted word count.
- ADDR_STEP, 1: increment added to mem_addr per word written.
- TIMEOUT_CYCLES, 50_000_000: mid-frame inter-byte timeout in CLK cycles; 0 disables the timeout.
- AUTO_START, 0: 1 = DONE advances to RUN automatically; 0 = wait for a start pulse.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- reload_n  in  1  synchronous active-low reload request (level).
- start  in  1  one-cycle run request, honoured only in DONE.
- rx_byte  in  8  byte from uart_rx.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  IW  assembled word.
- loaded_count  out  16  words written in the current or last frame.
- cpu_rst  out  1  active-high core reset.
- cpu_run_en  out  1  core run enable.
- done  out  1  frame accepted.
- err  out  1  frame rejected.
- err_code  out  2  00 none, 01 count>DEPTH, 10 checksum, 11 timeout.
- state  out  3  current state, for debug LEDs.

Behaviour:
- States and encodings: RUN=0, IDLE=1, CNT_MSB=2, DATA=3, CSUM=4, DONE=5, ERROR=6.
- RESET low (async): state=RUN; mem_we=0; mem_addr=0; mem_wdata=0; loaded_count=0; err_code=00; byte index=0; checksum accumulator=0; timeout counter=0. Memory contents are left untouched.
- reload_n low: state=IDLE next cycle from any state. It clears the address, count, checksum, err_code and byte index, and overrides a coincident rx_valid (that byte is dropped).
- IDLE: on rx_valid, latch the count LSB, xor it into csum, go to CNT_MSB.
- CNT_MSB: on rx_valid, form count = {byte, lsb}.
  - count > DEPTH → ERROR, err_code=01.
  - count == 0 → CSUM.
  - otherwise → DATA.
- DATA:
  - Byte k of each word lands in bits [8k+7:8k] of mem_wdata; every byte is xored into csum.
  - On byte WORD_BYTES-1, mem_we pulses high for exactly one cycle, one cycle after that rx_valid (registered), with the assembled mem_wdata and the current mem_addr.
  - In the cycle after the pulse, mem_addr += ADDR_STEP (wraps modulo 2^ADDR_W) and loaded_count += 1.
  - When the written word is word number count, go to CSUM.
- CSUM: on rx_valid, compare the byte with csum.
  - Equal → DONE.
  - Not equal → ERROR, err_code=10.
- DONE:
  - AUTO_START=1: advance to RUN next cycle.
  - AUTO_START=0: start high → RUN.
- RUN: rx_valid and start are ignored.
- ERROR: rx_valid and start are ignored; leave only via reload_n or RESET.
- Timeout: the counter clears on each rx_valid and counts only in CNT_MSB, DATA and CSUM. When it reaches TIMEOUT_CYCLES-1 with no byte: → ERROR, err_code=11.
- Combinational decodes from the state register:
  - cpu_rst = 1 unless state ∈ {DONE, RUN}.
  - cpu_run_en = (state==RUN).
  - done = (state==DONE or state==RUN) and err_code==00.
  - err = (state==ERROR).
- If RESET asserts mid-load, the partial memory image stays; the state goes to RUN per reset rules, and software must reload.
- rx_valid on consecutive cycles is supported. At most one mem_we is issued per WORD_BYTES bytes.

Decomposition:
- Package uart_loader_pkg holds:
  - the state encodings;
  - the err_code constants;
  - the frame header size (2 bytes).
- One natural sub-module, loader_word_asm: byte-lane index counter, little-endian shift-in, and word_ready strobe, parametrised by WORD_BYTES.

Test Plan:
- WORD_BYTES=2, AUTO_START=0: send 02 00 34 12 CD AB 42 → mem_we at addr0=0x1234 and addr1=0xABCD; then DONE, cpu_rst=0, loaded_count=2; a start pulse gives RUN with cpu_run_en=1.
- Same frame with checksum 43 → both writes occur, then ERROR with err_code=10 and cpu_rst=1; start is ignored.
- DEPTH=256, count bytes 01 01 (257) → ERROR with err_code=01 on the cycle after the second byte; no mem_we.
- TIMEOUT_CYCLES=1000: send 01 00 34, then silence → ERROR with err_code=11 exactly 1000 cycles after the last rx_valid. The same test in IDLE never times out.
- Send 00 00 00 → DONE, no mem_we, loaded_count=0. With AUTO_START=1 the block enters RUN one cycle later.
- reload_n low coincident with rx_valid mid-DATA → IDLE, mem_addr=0, byte dropped; a following valid frame loads correctly. Asserting RESET async mid-frame → immediate RUN with mem_we=0.
